// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// scan FSM states, the BCD segment table and the all-off output codes.
package seg_pkg;

  typedef enum logic {
    BLANK,
    DRIVE
  } scan_state_e;

  localparam logic [6:0] BLANK_SEG  = 7'h7F;
  localparam logic [7:0] ALL_OFF_AN = 8'hFF;

  // Active-low segments, bit6=a .. bit0=g; codes 10..15 are dark.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD to active-low seven-segment decoder.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[bcd_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with shadow/active digit banks.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEAD_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_idx,
  input  logic [3:0] wr_data,
  input  logic       wr_commit,
  output logic [7:0] an_o,
  output logic [6:0] seg_o
);

  localparam int MAX_CYC = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);

  scan_state_e      state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic [7:0][3:0]  shadow_q, shadow_d;
  logic [7:0][3:0]  active_q, active_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_end;
  logic [3:0]       digit_val;
  logic [6:0]       dec_seg;

  assign wr_ready = !pending_q;
  assign an_o     = an_q;
  assign seg_o    = seg_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + CNT_W'(1);
    frame_end = 1'b0;
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d   = BLANK;
          cnt_d     = '0;
          idx_d     = idx_q + 3'd1;
          frame_end = (idx_q == 3'd7);
        end
      end
    endcase
  end

  // A write accepted together with a commit lands in shadow_q before the
  // boundary copy, because the copy only happens on a later frame edge.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (wr_valid && wr_ready) shadow_d[wr_idx] = wr_data;
    if (wr_commit && wr_ready) pending_d = 1'b1;
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic [2:0] lz_top;

  always_comb begin
    lz_top = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (active_q[i] != 4'd0 && active_q[i] <= 4'd9) lz_top = 3'(i);
    end
    digit_val = (idx_q > lz_top) ? 4'hF : active_q[idx_q];
  end
`else
  assign digit_val = active_q[idx_q];
`endif

  seg_decode u_decode (
    .bcd_i (digit_val),
    .seg_o (dec_seg)
  );

  // Outputs are computed from the next state so they switch on the same
  // edge as the FSM; idx_q is already the new digit when DRIVE is entered.
  always_comb begin
    an_d  = ALL_OFF_AN;
    seg_d = BLANK_SEG;
    if (state_d == DRIVE) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = dec_seg;
    end
  end

  // NOTE: the digit banks are reset too, so the display starts dark rather than
  // showing power-up garbage; keep this in mind before mapping them to RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BLANK;
      idx_q     <= 3'd0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      shadow_q  <= {8{4'hF}};
      active_q  <= {8{4'hF}};
      an_q      <= ALL_OFF_AN;
      seg_q     <= BLANK_SEG;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=4, DEAD_CYC=1 (40-cycle frame);
// leading-zero expectations follow SEG_LZ_BLANK_EN.
module tb_seg_scan_ctrl;

  localparam int FRAME = 40;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_9   = 7'b0000100;
`ifdef SEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_idx = 3'd0;
  logic [3:0] wr_data = 4'd0;
  logic       wr_commit = 1'b0;
  logic [7:0] an_o;
  logic [6:0] seg_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  seg_scan_ctrl #(.SCAN_DIV(4), .DEAD_CYC(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .wr_commit (wr_commit),
    .an_o      (an_o),
    .seg_o     (seg_o)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the frame boundary edge leaves cyc % 40 == 0.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_phase(input int ph);
    int n = 0;
    while (((cyc % FRAME) != ph) && (n < 2 * FRAME)) begin
      @(negedge clk);
      n++;
    end
    if ((cyc % FRAME) != ph) begin
      checks++; errors++;
      $display("FAIL wait_phase: got phase %0d want %0d", cyc % FRAME, ph);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!wr_ready && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout: got %b want 1", name, wr_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (an_o !== 8'hFF) begin errors++; $display("FAIL rst_an: got %h want ff", an_o); end
    checks++;
    if (seg_o !== SEG_OFF) begin errors++; $display("FAIL rst_seg: got %b want %b", seg_o, SEG_OFF); end
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", wr_ready); end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (an_o !== 8'hFE) begin errors++; $display("FAIL rel_an_c%0d: got %h want fe", k, an_o); end
      checks++;
      if (seg_o !== SEG_OFF) begin errors++; $display("FAIL rel_seg_c%0d: got %b want %b", k, seg_o, SEG_OFF); end
    end
    @(negedge clk);
    checks++;
    if (an_o !== 8'hFF) begin errors++; $display("FAIL rel_dead_an: got %h want ff", an_o); end
    @(negedge clk);
    checks++;
    if (an_o !== 8'hFD) begin errors++; $display("FAIL rel_d1_an: got %h want fd", an_o); end
  endtask

  task automatic test_write_commit();
    wait_phase(10);
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL wc_ready_before: got %b want 1", wr_ready); end
    wr_valid = 1'b1; wr_idx = 3'd3; wr_data = 4'd5; wr_commit = 1'b1;
    @(negedge clk);
    wr_commit = 1'b0; wr_data = 4'd8;
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL wc_stall: got %b want 0", wr_ready); end
    wait_ready("wc");
    wr_valid = 1'b0;
    checks++;
    if ((cyc % FRAME) != 0) begin errors++; $display("FAIL wc_ready_edge: got phase %0d want 0", cyc % FRAME); end
    wait_phase(16);
    checks++;
    if (an_o !== 8'hF7) begin errors++; $display("FAIL wc_d3_an: got %h want f7", an_o); end
    checks++;
    if (seg_o !== SEG_5) begin errors++; $display("FAIL wc_d3_seg: got %b want %b", seg_o, SEG_5); end
    wait_phase(21);
    checks++;
    if (an_o !== 8'hEF) begin errors++; $display("FAIL wc_d4_an: got %h want ef", an_o); end
    checks++;
    if (seg_o !== SEG_OFF) begin errors++; $display("FAIL wc_d4_seg: got %b want %b", seg_o, SEG_OFF); end
  endtask

  task automatic test_simultaneous();
    wait_phase(30);
    wr_valid = 1'b1; wr_idx = 3'd0; wr_data = 4'd9; wr_commit = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; wr_commit = 1'b0;
    wait_ready("sim");
    @(negedge clk);
    checks++;
    if (an_o !== 8'hFE) begin errors++; $display("FAIL sim_d0_an: got %h want fe", an_o); end
    checks++;
    if (seg_o !== SEG_9) begin errors++; $display("FAIL sim_d0_seg: got %b want %b", seg_o, SEG_9); end
    wait_phase(16);
    checks++;
    if (seg_o !== SEG_5) begin errors++; $display("FAIL sim_d3_seg: got %b want %b", seg_o, SEG_5); end
  endtask

  task automatic test_wrap();
    int pos;
    int d;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    wait_phase(0);
    for (int i = 0; i <= FRAME; i++) begin
      pos = (cyc + FRAME - 1) % FRAME;
      d   = pos / 5;
      if ((pos % 5) < 4) begin
        exp_an  = ~(8'b1 << d);
        exp_seg = (d == 0) ? SEG_9 : (d == 3) ? SEG_5 : SEG_OFF;
      end else begin
        exp_an  = 8'hFF;
        exp_seg = SEG_OFF;
      end
      checks++;
      if (an_o !== exp_an) begin errors++; $display("FAIL wrap_an_p%0d: got %h want %h", cyc % FRAME, an_o, exp_an); end
      checks++;
      if (seg_o !== exp_seg) begin errors++; $display("FAIL wrap_seg_p%0d: got %b want %b", cyc % FRAME, seg_o, exp_seg); end
      @(negedge clk);
    end
  endtask

  task automatic test_lz();
    logic [3:0] vals [8];
    logic [6:0] exp_seg;
    vals = '{4'd7, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    wait_phase(5);
    for (int d = 7; d >= 0; d--) begin
      wr_valid = 1'b1; wr_idx = 3'(d); wr_data = vals[d]; wr_commit = (d == 0);
      @(negedge clk);
    end
    wr_valid = 1'b0; wr_commit = 1'b0;
    wait_ready("lz");
    for (int d = 0; d < 8; d++) begin
      wait_phase(5 * d + 1);
      if (d >= 3)      exp_seg = LZ ? SEG_OFF : SEG_0;
      else if (d == 2) exp_seg = SEG_1;
      else if (d == 1) exp_seg = SEG_0;
      else             exp_seg = SEG_7;
      checks++;
      if (an_o !== ~(8'b1 << d)) begin errors++; $display("FAIL lz_an_d%0d: got %h want %h", d, an_o, ~(8'b1 << d)); end
      checks++;
      if (seg_o !== exp_seg) begin errors++; $display("FAIL lz_seg_d%0d: got %b want %b", d, seg_o, exp_seg); end
    end
  endtask

  task automatic test_reset_mid();
    wait_phase(12);
    wr_valid = 1'b1; wr_idx = 3'd0; wr_data = 4'd2; wr_commit = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; wr_commit = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL rm_stall: got %b want 0", wr_ready); end
    wait_phase(25);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (an_o !== 8'hFF) begin errors++; $display("FAIL rm_an: got %h want ff", an_o); end
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b want 1", wr_ready); end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (an_o !== 8'hFE) begin errors++; $display("FAIL rm_an_c%0d: got %h want fe", k, an_o); end
      checks++;
      if (seg_o !== SEG_OFF) begin errors++; $display("FAIL rm_seg_c%0d: got %b want %b", k, seg_o, SEG_OFF); end
      @(negedge clk);
    end
    wait_phase(39);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (an_o !== 8'hFE) begin errors++; $display("FAIL rm_next_an: got %h want fe", an_o); end
    checks++;
    if (seg_o !== SEG_OFF) begin errors++; $display("FAIL rm_next_seg: got %b want %b", seg_o, SEG_OFF); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_commit();
    test_simultaneous();
    test_wrap();
    test_lz();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
